// File: rtl/mp_add_seq_pkg.sv
// Shared definitions for the byte-serial add/subtract controllers:
// FSM state encodings and index-width helper.
package mp_add_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A single-byte operand still needs a one-bit index register.
    function automatic int idx_width(input int nbytes);
        return (nbytes <= 1) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/fa_8bits.sv
// Purely combinational 8-bit ripple-carry adder, shared by the
// multi-precision sequencers.
module fa_8bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[8];
    end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: one fa_8bits reused LSB byte
// first, carry held between bytes, result published only when complete.
module mp_add_seq
    import mp_add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] result,
    output logic                cout,
    output logic                ovf
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = idx_width(NBYTES);

    state_t                  state;
    logic [IW-1:0]           idx;
    logic                    carry;
    logic [NBYTES-1:0][7:0]  opa;
    logic [NBYTES-1:0][7:0]  opb;
    logic [NBYTES-1:0][7:0]  work;
    logic [NBYTES-1:0][7:0]  next_work;

    logic [7:0] i0;
    logic [7:0] i1;
    logic [7:0] fa_sum;
    logic       fa_cout;
    logic       last_byte;

    fa_8bits u_fa (
        .a    (i0),
        .b    (i1),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // opb already holds b or ~b, so the adder never sees the sub flag.
    always_comb begin
        i0        = '0;
        i1        = '0;
        next_work = work;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == IW'(i)) begin
                i0           = opa[i];
                i1           = opb[i];
                next_work[i] = fa_sum;
            end
        end
    end

    assign last_byte = (idx == IW'(NBYTES - 1));
    assign busy      = ~ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            work   <= '0;
            ready  <= 1'b1;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= a;
                        opb   <= b ^ {W{sub}};
                        carry <= sub;
                        idx   <= '0;
                        ready <= 1'b0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    work  <= next_work;
                    carry <= fa_cout;
                    idx   <= idx + 1'b1;
                    if (last_byte) begin
                        idx    <= '0;
                        result <= next_work;
                        cout   <= fa_cout;
                        ovf    <= (i0[7] == i1[7]) & (fa_sum[7] != i0[7]);
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
